// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide engine.
//   - Op encodings for the Op port (MD_MULT .. MD_MSUBU)
//   - FSM state encoding
//   - Op-class helpers used by the engine and the arithmetic block
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MADD  = 3'b100;
  localparam logic [2:0] MD_MADDU = 3'b101;
  localparam logic [2:0] MD_MSUB  = 3'b110;
  localparam logic [2:0] MD_MSUBU = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  // div and divu are the only ops with bits [2:1] == 01
  function automatic logic is_div(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

  // Bit 0 set selects the unsigned variant for every op class
  function automatic logic is_signed_op(input logic [2:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_engine_if.sv
// muldiv_engine_if: EX-stage command/result bundle of the mul/div engine.
//   Start/Op/D1/D2 : launch an operation
//   We/HiLo/D1     : mthi/mtlo direct write
//   Cancel         : exception flush
//   Busy/Done/HI/LO: status and HI/LO register contents
// master = pipeline side, slave = engine side.
interface muldiv_engine_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] D1;
  logic [WIDTH-1:0] D2;
  logic             We;
  logic             HiLo;
  logic             Cancel;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output Start, Op, D1, D2, We, HiLo, Cancel,
                  input  Busy, Done, HI, LO);
  modport slave  (input  Start, Op, D1, D2, We, HiLo, Cancel,
                  output Busy, Done, HI, LO);
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational datapath of the mul/div engine.
//   op     : latched operation
//   a, b   : latched rs/rt operands
//   hi, lo : current HI/LO (accumulator for madd/msub)
//   res    : 2*WIDTH result, {HI,LO}
// Division: quotient truncates toward zero, remainder follows the dividend's
// sign. Divide by zero gives {a, all ones}. Signed MIN/-1 falls out of the
// magnitude datapath naturally (|MIN| negated back to MIN, remainder 0).
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] res
);

  localparam int W2 = 2 * WIDTH;

  logic             sgn, a_neg, b_neg;
  logic [W2-1:0]    ea, eb, prod, acc;
  logic [WIDTH-1:0] ua, ub, q_mag, r_mag, q, r;

  always_comb begin
    sgn   = is_signed_op(op);
    // Extending to 2W and keeping the low 2W bits of the product yields the
    // exact signed or unsigned product with a single multiplier.
    ea    = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    eb    = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod  = ea * eb;
    acc   = {hi, lo};

    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    ua    = a_neg ? -a : a;
    ub    = b_neg ? -b : b;
    q_mag = (ub == '0) ? '0 : ua / ub;
    r_mag = (ub == '0) ? '0 : ua % ub;
    q     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    r     = a_neg ? -r_mag : r_mag;

    res = prod;
    if (is_div(op))
      res = (b == '0) ? {a, {WIDTH{1'b1}}} : {r, q};
    else if (op[2])
      res = op[1] ? (acc - prod) : (acc + prod);
  end

endmodule

// File: rtl/muldiv_engine.sv
// muldiv_engine: multi-cycle multiply/divide unit owning HI/LO.
//   Clk   : clock, rising edge
//   Reset : synchronous, active-low
//   bus   : muldiv_engine_if slave (Start/Op/D1/D2/We/HiLo/Cancel in,
//           Busy/Done/HI/LO out)
// Start in IDLE latches operands and runs for MUL_LAT or DIV_LAT cycles,
// committing {HI,LO} on the last one; Done pulses the cycle after commit.
module muldiv_engine
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input logic            Clk,
  input logic            Reset,
  muldiv_engine_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic [2*WIDTH-1:0] res;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .hi  (hi_q),
    .lo  (lo_q),
    .res (res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Start has priority over We; Cancel suppresses both
        if (bus.Start && !bus.Cancel) begin
          op_d    = bus.Op;
          a_d     = bus.D1;
          b_d     = bus.D2;
          cnt_d   = is_div(bus.Op) ? CW'(DIV_LAT) : CW'(MUL_LAT);
          state_d = S_RUN;
        end else if (bus.We && !bus.Cancel) begin
          if (bus.HiLo) hi_d = bus.D1;
          else          lo_d = bus.D1;
        end
      end
      S_RUN: begin
        if (bus.Cancel) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(1)) begin
          {hi_d, lo_d} = res;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.Busy = (state_q == S_RUN);
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
